// File: rtl/core_debug_scan_host_pkg.sv
// Shared constants for the virtual-JTAG debug scan host: FSM encoding,
// debug IR opcodes and default register geometry.
package core_debug_scan_host_pkg;

  localparam int unsigned DR_WIDTH_DEF = 38;
  localparam int unsigned IR_WIDTH_DEF = 2;
  localparam int unsigned ST_W         = 3;

  // Scan sequence states
  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_UIR  = 3'd1;
  localparam logic [ST_W-1:0] ST_CDR  = 3'd2;
  localparam logic [ST_W-1:0] ST_SDR  = 3'd3;
  localparam logic [ST_W-1:0] ST_UDR  = 3'd4;
  localparam logic [ST_W-1:0] ST_RTI  = 3'd5;
  localparam logic [ST_W-1:0] ST_RESP = 3'd6;

  // Debug instruction opcodes
  localparam logic [IR_WIDTH_DEF-1:0] IR_MONITOR   = 2'b00;
  localparam logic [IR_WIDTH_DEF-1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [IR_WIDTH_DEF-1:0] IR_BREAK     = 2'b10;
  localparam logic [IR_WIDTH_DEF-1:0] IR_TRACECTRL = 2'b11;

  // One-hot strobe pattern {uir, cdr, sdr, udr, rti} for a state
  function automatic logic [4:0] strobes_for(input logic [ST_W-1:0] st);
    case (st)
      ST_UIR:  return 5'b10000;
      ST_CDR:  return 5'b01000;
      ST_SDR:  return 5'b00100;
      ST_UDR:  return 5'b00010;
      ST_RTI:  return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/debug_tck_gen.sv
// Divided virtual TCK: low for TCK_DIV clk cycles, then high for TCK_DIV.
// Pulses flag the cycle before tck rises and the last cycle of a period.
module debug_tck_gen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic period_start_c,
  output logic rise_c
);

  localparam int unsigned PH_W = 8;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TCK_DIV - 1);

  logic [PH_W-1:0] ph_q;
  logic            ph_last_c;

  assign ph_last_c = (ph_q == PH_LAST);

  // Phase counter restarts at the low phase whenever the scan is not running
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      ph_q <= '0;
      tck  <= 1'b0;
    end else if (ph_last_c) begin
      ph_q <= '0;
      tck  <= ~tck;
    end else begin
      ph_q <= ph_q + PH_W'(1);
    end
  end

  // The next clk edge raises tck / opens a new tck period
  assign rise_c         = run && !tck && ph_last_c;
  assign period_start_c = run &&  tck && ph_last_c;

endmodule

// File: rtl/core_debug_scan_host.sv
// Host side of a virtual-JTAG debug port: loads an instruction, shifts one
// data register through the target and returns the captured bits.
module core_debug_scan_host
  import core_debug_scan_host_pkg::*;
#(
  parameter int unsigned TCK_DIV  = 2,
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam int unsigned BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  logic [ST_W-1:0]     state_q, state_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DR_WIDTH-1:0] dr_q;
  logic [4:0]          strb_d;
  logic                tdi_d;
  logic                run_c;
  logic                period_start_c;
  logic                rise_c;
  logic                cmd_fire_c;
  logic                rsp_fire_c;

  assign run_c      = (state_q != ST_IDLE) && (state_q != ST_RESP);
  assign cmd_fire_c = cmd_valid && cmd_ready;
  assign rsp_fire_c = rsp_valid && rsp_ready;

  debug_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk            (clk),
    .reset          (reset),
    .run            (run_c),
    .tck            (vji_tck),
    .period_start_c (period_start_c),
    .rise_c         (rise_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
    end
  end

  // Next state, bit index and next-cycle pin values
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    strb_d  = 5'b00000;
    tdi_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_fire_c)     state_d = ST_UIR;
      ST_UIR:  if (period_start_c) state_d = ST_CDR;
      ST_CDR:  if (period_start_c) state_d = ST_SDR;
      ST_SDR: begin
        if (period_start_c) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_UDR;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_UDR:  if (period_start_c) state_d = ST_RTI;
      ST_RTI:  if (period_start_c) state_d = ST_RESP;
      ST_RESP: if (rsp_fire_c)     state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    strb_d = strobes_for(state_d);
    if (state_d == ST_SDR) begin
      tdi_d = dr_q[bit_d];
    end
  end

  // Handshake flags and target-side control pins
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      vji_tdi   <= 1'b0;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      vji_rti   <= 1'b0;
    end else begin
      cmd_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RESP);
      vji_tdi   <= tdi_d;
      {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} <= strb_d;
    end
  end

  // Command latch and capture of the target's returns at tck rise
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_q       <= '0;
      vji_ir_in  <= '0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else begin
      if (cmd_fire_c) begin
        dr_q      <= cmd_dr;
        vji_ir_in <= cmd_ir;
      end
      if ((state_q == ST_SDR) && rise_c) begin
        rsp_dr[bit_q] <= vji_tdo;
      end
      if ((state_q == ST_CDR) && rise_c) begin
        rsp_ir_out <= vji_ir_out;
      end
    end
  end

endmodule
